far_path_pipe: RTL and testbench

- Pipelined, parametrised far-path significand adder/subtractor for the floating-point MAC.
- Aligns the smaller operand, performs the effective add or subtract, rounds round-to-nearest-even (RNE) and normalises by at most one position.
- Generalises the 4-bit combinational far path to FRAC_W/EXP_W widths.
- Adds a 3-stage valid/ready pipeline, shift-amount saturation with sticky collapse, and exponent overflow/underflow and out-of-domain flags.

---
 rtl/far_path_pipe.sv | 176 +++++++++++++++++
 tb/tb_far_path_pipe.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/far_path_pipe.sv
// Far-path significand adder/subtractor: aligns B with G/R/S, adds or subtracts,
// rounds to nearest-even, normalises by one position and flags exponent range.
module far_path_pipe #(
    parameter int FRAC_W = 4,
    parameter int EXP_W  = 4,
    parameter int D_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FRAC_W-1:0] fraca_c,
    input  logic [FRAC_W-1:0] fracb_c,
    input  logic [EXP_W-1:0]  exp_large,
    input  logic [D_W-1:0]    d,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FRAC_W-1:0] frac_ans_far,
    output logic [EXP_W-1:0]  exp_ans_far,
    output logic              ovf,
    output logic              unf,
    output logic              path_err
);
    localparam int XW = FRAC_W + 3;
    localparam int TW = 2 * FRAC_W + 2;
    localparam logic signed [EXP_W+1:0] ADJ_UP = {{(EXP_W + 1){1'b0}}, 1'b1};
    localparam logic signed [EXP_W+1:0] ADJ_DN = '1;

    typedef enum logic [1:0] {MODE_CARRY, MODE_NORM, MODE_LEFT} mode_e;

    function automatic logic rne_up(input logic lsb, input logic rbit, input logic stk);
        return rbit & (stk | lsb);
    endfunction

    logic              vld_p1_q, vld_p2_q, vld_p3_q;
    logic              rdy_p2, rdy_p3;
    logic [FRAC_W-1:0] a_p1_q;
    logic [XW-1:0]     bx_p1_q;
    logic [EXP_W-1:0]  exp_p1_q, exp_p2_q;
    logic              sub_p1_q, perr_p1_q, perr_p2_q;
    logic [FRAC_W:0]   rnd_p2_q;
    mode_e             mode_p2_q;

    assign rdy_p3    = ~vld_p3_q | out_ready;
    assign rdy_p2    = ~vld_p2_q | rdy_p3;
    assign in_ready  = ~vld_p1_q | rdy_p2;
    assign out_valid = vld_p3_q;

    // S1: align B into FRAC_W+G+R+S, saturate large shifts to a lone sticky bit
    logic [TW-1:0] sh_full;
    logic [XW-1:0] bx_d;
    logic          perr_d;
    always_comb begin
        sh_full = {fracb_c, {(FRAC_W + 2){1'b0}}} >> d;
        if (32'(d) >= 32'(FRAC_W + 2)) bx_d = {{(XW - 1){1'b0}}, 1'b1};
        else                           bx_d = {sh_full[TW-1 -: FRAC_W+2], |sh_full[FRAC_W-1:0]};
        if (sub) bx_d = ~bx_d + 1'b1;
        perr_d = sub & (32'(d) < 32'd2);
    end

    // S2: add, pick the rounding window for the coming normalisation, choose w or w+1
    logic [XW:0]     sum_p1;
    logic [FRAC_W:0] base_p1, rnd_d;
    logic            lsb_p1, rbit_p1, stk_p1;
    mode_e           mode_d;
    always_comb begin
        sum_p1  = {1'b0, a_p1_q, 3'b000} + {1'b0, bx_p1_q};
        mode_d  = MODE_LEFT;
        base_p1 = {1'b0, sum_p1[XW-2:2]};
        lsb_p1  = sum_p1[2];
        rbit_p1 = sum_p1[1];
        stk_p1  = sum_p1[0];
        // carry out of a subtraction is the two's-complement wrap, not a real carry
        if (sum_p1[XW] & ~sub_p1_q) begin
            mode_d  = MODE_CARRY;
            base_p1 = {1'b0, sum_p1[XW:4]};
            lsb_p1  = sum_p1[4];
            rbit_p1 = sum_p1[3];
            stk_p1  = |sum_p1[2:0];
        end else if (sum_p1[XW-1]) begin
            mode_d  = MODE_NORM;
            base_p1 = {1'b0, sum_p1[XW-1:3]};
            lsb_p1  = sum_p1[3];
            rbit_p1 = sum_p1[2];
            stk_p1  = |sum_p1[1:0];
        end
        rnd_d = rne_up(lsb_p1, rbit_p1, stk_p1) ? base_p1 + 1'b1 : base_p1;
    end

    // S3: absorb any rounding carry, adjust exponent, apply range and path flags
    logic [FRAC_W-1:0]       frac_n, frac_d;
    logic signed [EXP_W+1:0] adj, exp_sum;
    logic [EXP_W-1:0]        exp_d;
    logic                    ovf_d, unf_d, perr_o_d;
    always_comb begin
        frac_n = rnd_p2_q[FRAC_W-1:0];
        adj    = '0;
        case (mode_p2_q)
            MODE_CARRY: adj = ADJ_UP;
            MODE_LEFT: begin
                if (rnd_p2_q[FRAC_W]) frac_n = rnd_p2_q[FRAC_W:1];
                else                  adj    = ADJ_DN;
            end
            default: begin
                if (rnd_p2_q[FRAC_W]) begin
                    frac_n = rnd_p2_q[FRAC_W:1];
                    adj    = ADJ_UP;
                end
            end
        endcase
        exp_sum  = $signed({2'b00, exp_p2_q}) + adj;
        frac_d   = frac_n;
        exp_d    = exp_sum[EXP_W-1:0];
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        perr_o_d = 1'b0;
        if (perr_p2_q) begin
            frac_d   = '0;
            exp_d    = '0;
            perr_o_d = 1'b1;
        end else if (exp_sum[EXP_W+1]) begin
            frac_d = '0;
            exp_d  = '0;
            unf_d  = 1'b1;
        end else if (exp_sum[EXP_W]) begin
            frac_d = '1;
            exp_d  = '1;
            ovf_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
        end else begin
            if (in_ready) vld_p1_q <= in_valid;
            if (rdy_p2)   vld_p2_q <= vld_p1_q;
            if (rdy_p3)   vld_p3_q <= vld_p2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid & in_ready) begin
            a_p1_q    <= fraca_c;
            bx_p1_q   <= bx_d;
            exp_p1_q  <= exp_large;
            sub_p1_q  <= sub;
            perr_p1_q <= perr_d;
        end
        if (rdy_p2 & vld_p1_q) begin
            rnd_p2_q  <= rnd_d;
            mode_p2_q <= mode_d;
            exp_p2_q  <= exp_p1_q;
            perr_p2_q <= perr_p1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frac_ans_far <= '0;
            exp_ans_far  <= '0;
            ovf          <= 1'b0;
            unf          <= 1'b0;
            path_err     <= 1'b0;
        end else if (rdy_p3 & vld_p2_q) begin
            frac_ans_far <= frac_d;
            exp_ans_far  <= exp_d;
            ovf          <= ovf_d;
            unf          <= unf_d;
            path_err     <= perr_o_d;
        end
    end
endmodule

// File: tb/tb_far_path_pipe.sv
// Bench for far_path_pipe: directed vectors plus randomized streams checked
// against an exact-arithmetic rounding model and an in-order scoreboard.
`timescale 1ns/1ps
module tb_far_path_pipe;
    localparam int FW = 4;
    localparam int EW = 4;
    localparam int DW = 4;

    logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic          in_ready, out_valid, ovf, unf, path_err;
    logic [FW-1:0] fraca_c = '0, fracb_c = '0, frac_ans_far;
    logic [EW-1:0] exp_large = '0, exp_ans_far;
    logic [DW-1:0] d = '0;
    int            n_checks = 0, n_fail = 0;

    typedef struct {
        logic [FW-1:0] fa;
        logic [FW-1:0] fb;
        logic [EW-1:0] e;
        logic [DW-1:0] d;
        logic          sub;
    } stim_t;

    typedef struct packed {
        logic [FW-1:0] frac;
        logic [EW-1:0] ex;
        logic          ov;
        logic          un;
        logic          pe;
    } res_t;

    stim_t stim_q[$];
    res_t  sb_q[$];

    far_path_pipe #(.FRAC_W(FW), .EXP_W(EW), .D_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fraca_c(fraca_c), .fracb_c(fracb_c), .exp_large(exp_large), .d(d), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .frac_ans_far(frac_ans_far),
        .exp_ans_far(exp_ans_far), .ovf(ovf), .unf(unf), .path_err(path_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Exact value X = A*2^d +/- B, normalised to FW bits and rounded to nearest-even.
    function automatic res_t model(input stim_t s);
        res_t   r;
        longint x, q, rem, half;
        int     p, sh, e;
        r = '0;
        if (s.sub && s.d < 2) begin
            r.pe = 1'b1;
            return r;
        end
        x = s.sub ? (longint'(s.fa) << s.d) - longint'(s.fb)
                  : (longint'(s.fa) << s.d) + longint'(s.fb);
        p = 0;
        while ((x >> (p + 1)) != 0) p++;
        sh = p - (FW - 1);
        if (sh > 0) begin
            q    = x >> sh;
            rem  = x - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (longint'(1) << FW)) begin
                q = q >> 1;
                sh++;
            end
        end else begin
            q = x << (-sh);
        end
        e = int'(s.e) + sh - int'(s.d);
        if (e > (1 << EW) - 1) begin
            r.frac = '1;
            r.ex   = '1;
            r.ov   = 1'b1;
        end else if (e < 0) begin
            r.un = 1'b1;
        end else begin
            r.frac = FW'(q);
            r.ex   = EW'(e);
        end
        return r;
    endfunction

    function automatic stim_t rand_stim();
        stim_t         s;
        logic [FW-1:0] t;
        s.fa  = {1'b1, (FW-1)'($urandom)};
        s.fb  = {1'b1, (FW-1)'($urandom)};
        s.e   = EW'($urandom);
        s.d   = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 6));
        s.sub = 1'($urandom_range(0, 1));
        if (s.d == 0 && s.fb > s.fa) begin
            t    = s.fa;
            s.fa = s.fb;
            s.fb = t;
        end
        return s;
    endfunction

    task automatic drive(input stim_t s);
        fraca_c   = s.fa;
        fracb_c   = s.fb;
        exp_large = s.e;
        d         = s.d;
        sub       = s.sub;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_checks++;
        if ({frac_ans_far, exp_ans_far, ovf, unf, path_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b_%b_%b%b%b want all zero",
                     frac_ans_far, exp_ans_far, ovf, unf, path_err);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        stim_t vs[9];
        res_t  vr[9];
        res_t  got;
        vs[0] = '{4'b1000, 4'b1000, 4'd5,  4'd0,  1'b0}; vr[0] = '{4'b1000, 4'd6,  1'b0, 1'b0, 1'b0};
        vs[1] = '{4'b1000, 4'b1000, 4'd5,  4'd2,  1'b1}; vr[1] = '{4'b1100, 4'd4,  1'b0, 1'b0, 1'b0};
        vs[2] = '{4'b1111, 4'b1000, 4'd5,  4'd4,  1'b0}; vr[2] = '{4'b1000, 4'd6,  1'b0, 1'b0, 1'b0};
        vs[3] = '{4'b1000, 4'b1111, 4'd5,  4'd15, 1'b0}; vr[3] = '{4'b1000, 4'd5,  1'b0, 1'b0, 1'b0};
        vs[4] = '{4'b1000, 4'b1000, 4'd15, 4'd0,  1'b0}; vr[4] = '{4'b1111, 4'd15, 1'b1, 1'b0, 1'b0};
        vs[5] = '{4'b1000, 4'b1000, 4'd0,  4'd2,  1'b1}; vr[5] = '{4'b0000, 4'd0,  1'b0, 1'b1, 1'b0};
        vs[6] = '{4'b1010, 4'b1000, 4'd7,  4'd1,  1'b1}; vr[6] = '{4'b0000, 4'd0,  1'b0, 1'b0, 1'b1};
        vs[7] = '{4'b1000, 4'b1111, 4'd5,  4'd15, 1'b1}; vr[7] = '{4'b1000, 4'd5,  1'b0, 1'b0, 1'b0};
        vs[8] = '{4'b1000, 4'b1000, 4'd5,  4'd4,  1'b0}; vr[8] = '{4'b1000, 4'd5,  1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            drive(vs[i]);
            in_valid = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            drive(rand_stim());
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL vec%0d_early1: out_valid got %b want 0", i, out_valid);
            end
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL vec%0d_early2: out_valid got %b want 0", i, out_valid);
            end
            @(negedge clk);
            got = {frac_ans_far, exp_ans_far, ovf, unf, path_err};
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL vec%0d_latency: out_valid got %b want 1", i, out_valid);
            end
            n_checks++;
            if (got !== vr[i]) begin
                n_fail++;
                $display("FAIL vec%0d_result: got frac=%b exp=%0d ovf=%b unf=%b perr=%b want frac=%b exp=%0d ovf=%b unf=%b perr=%b",
                         i, got.frac, got.ex, got.ov, got.un, got.pe,
                         vr[i].frac, vr[i].ex, vr[i].ov, vr[i].un, vr[i].pe);
            end
        end
    endtask

    // Drains stim_q through the DUT; every output is compared with the scoreboard head.
    task automatic test_stream(input int vmode, input int rmode, input int max_cyc,
                               output int nout, output int nperr, output int span);
        int   cyc, first, last;
        res_t got;
        cyc = 0;
        first = -1;
        last = -1;
        nout = 0;
        nperr = 0;
        while ((stim_q.size() != 0 || sb_q.size() != 0) && cyc < max_cyc) begin
            @(posedge clk);
            #1;
            if (stim_q.size() != 0 && (vmode == 0 || $urandom_range(0, 3) != 0)) begin
                drive(stim_q[0]);
                in_valid = 1'b1;
            end else begin
                drive(rand_stim());
                in_valid = 1'b0;
            end
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
            @(negedge clk);
            if (out_valid) begin
                got = {frac_ans_far, exp_ans_far, ovf, unf, path_err};
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_spurious: out_valid with nothing pending, got %b want no output", got);
                end else if (got !== sb_q[0]) begin
                    n_fail++;
                    $display("FAIL stream_result cyc%0d: got frac=%b exp=%0d flags=%b%b%b want frac=%b exp=%0d flags=%b%b%b",
                             cyc, got.frac, got.ex, got.ov, got.un, got.pe,
                             sb_q[0].frac, sb_q[0].ex, sb_q[0].ov, sb_q[0].un, sb_q[0].pe);
                end
                if (out_ready && sb_q.size() != 0) begin
                    void'(sb_q.pop_front());
                    nout++;
                    if (got.pe) nperr++;
                    if (first < 0) first = cyc;
                    last = cyc;
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(stim_q[0]));
                void'(stim_q.pop_front());
            end
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (cyc >= max_cyc) begin
            n_fail++;
            $display("FAIL stream_timeout: %0d inputs and %0d results still pending after %0d cycles, want 0",
                     stim_q.size(), sb_q.size(), cyc);
            stim_q.delete();
            sb_q.delete();
        end
        span = last - first;
    endtask

    task automatic test_back_to_back();
        int nout, nperr, span;
        for (int i = 0; i < 40; i++) stim_q.push_back(rand_stim());
        test_stream(0, 0, 200, nout, nperr, span);
        n_checks++;
        if (nout != 40) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results want 40", nout);
        end
        n_checks++;
        if (span != 39) begin
            n_fail++;
            $display("FAIL b2b_throughput: got span %0d cycles want 39", span);
        end
    endtask

    task automatic test_stall();
        int    nout, nperr, span;
        stim_t s;
        for (int i = 0; i < 8; i++) begin
            s = rand_stim();
            s.e = EW'(i + 3);
            if (i == 3) begin
                s.sub = 1'b1;
                s.d = DW'(1);
            end else if (s.sub && s.d < 2) begin
                s.d = DW'(2);
            end
            stim_q.push_back(s);
        end
        test_stream(0, 1, 200, nout, nperr, span);
        n_checks++;
        if (nout != 8) begin
            n_fail++;
            $display("FAIL stall_count: got %0d results want 8", nout);
        end
        n_checks++;
        if (nperr != 1) begin
            n_fail++;
            $display("FAIL stall_path_err: got %0d path_err results want 1", nperr);
        end
    endtask

    task automatic test_random();
        int nout, nperr, span;
        for (int i = 0; i < 150; i++) stim_q.push_back(rand_stim());
        test_stream(1, 2, 3000, nout, nperr, span);
        n_checks++;
        if (nout != 150) begin
            n_fail++;
            $display("FAIL random_count: got %0d results want 150", nout);
        end
    endtask

    task automatic test_reset_midstream();
        int nout, nperr, span;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        repeat (4) begin
            drive(rand_stim());
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_filled: out_valid got %b want 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: out_valid got %b want 0", out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_empty%0d: out_valid got %b want 0", i, out_valid);
            end
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_in_ready: got %b want 1", in_ready);
        end
        stim_q.push_back(rand_stim());
        test_stream(0, 0, 50, nout, nperr, span);
        n_checks++;
        if (nout != 1) begin
            n_fail++;
            $display("FAIL midrst_after: got %0d results want 1", nout);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
